// File: rtl/score_pulse_scheduler.sv
// Per-source saturating score accumulators drained round-robin into a single stream of
// one-cycle count pulses for the least-significant score digit.
module score_pulse_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned POINTS_WIDTH  = 6,
    parameter int unsigned PENDING_WIDTH = 8,
    parameter int unsigned PULSE_GAP     = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              add_pulse,
    input  logic [NUM_REQ*POINTS_WIDTH-1:0] add_points,
    input  logic                            freeze,
    output logic                            count_pulse,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy,
    output logic                            overflow
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GapW = (PULSE_GAP > 1) ? $clog2(PULSE_GAP + 1) : 1;
    localparam logic [PENDING_WIDTH-1:0] PendMax = '1;

    typedef enum logic [1:0] {StIdle, StLoad, StPulse, StGap} state_e;

    state_e                   state_q, state_d;
    logic [PENDING_WIDTH-1:0] pend_q [NUM_REQ];
    logic [PENDING_WIDTH-1:0] pend_d [NUM_REQ];
    logic [PENDING_WIDTH-1:0] drain_q, drain_d;
    logic [GapW-1:0]          gap_q, gap_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [IdxW-1:0]          last_q, last_d;
    logic                     pulse_q, pulse_d;
    logic                     ovf_q, ovf_d;
    logic                     pick_found;
    logic [IdxW-1:0]          pick_idx;
    logic                     any_pending;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = last_q;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            j = (int'(last_q) + 1 + k) % int'(NUM_REQ);
            if (!pick_found && pend_q[j] != '0) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'(j);
            end
        end
    end

    always_comb begin
        logic [PENDING_WIDTH:0] sum;
        sum         = '0;
        ovf_d       = ovf_q;
        any_pending = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            sum = {1'b0, pend_q[i]}
                + (PENDING_WIDTH + 1)'(add_points[i*POINTS_WIDTH +: POINTS_WIDTH]);
            pend_d[i] = pend_q[i];
            // The drained source restarts from any award landing in the LOAD cycle.
            if (state_q == StLoad && last_q == IdxW'(i)) begin
                pend_d[i] = add_pulse[i]
                          ? PENDING_WIDTH'(add_points[i*POINTS_WIDTH +: POINTS_WIDTH]) : '0;
            end else if (add_pulse[i]) begin
                if (sum[PENDING_WIDTH]) begin
                    pend_d[i] = PendMax;
                    ovf_d     = 1'b1;
                end else begin
                    pend_d[i] = sum[PENDING_WIDTH-1:0];
                end
            end
            if (pend_q[i] != '0) any_pending = 1'b1;
        end
    end

    // pulse_d predicts whether the next cycle emits a pulse, keeping count_pulse registered.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        gap_d   = gap_q;
        grant_d = grant_q;
        last_d  = last_q;
        pulse_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!freeze && pick_found) begin
                    last_d            = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = StLoad;
                end
            end
            StLoad: begin
                drain_d = pend_q[last_q];
                pulse_d = !freeze;
                state_d = StPulse;
            end
            StPulse: begin
                if (pulse_q) begin
                    drain_d = drain_q - 1'b1;
                    if (drain_q == PENDING_WIDTH'(1)) begin
                        state_d = StIdle;
                        grant_d = '0;
                    end else if (PULSE_GAP > 0) begin
                        state_d = StGap;
                        gap_d   = GapW'(PULSE_GAP);
                    end else begin
                        pulse_d = !freeze;
                    end
                end else begin
                    pulse_d = !freeze;
                end
            end
            StGap: begin
                if (!freeze) begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q == GapW'(1)) begin
                        state_d = StPulse;
                        pulse_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            for (int i = 0; i < int'(NUM_REQ); i++) pend_q[i] <= '0;
            drain_q <= '0;
            gap_q   <= '0;
            grant_q <= '0;
            last_q  <= IdxW'(NUM_REQ - 1);
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            drain_q <= drain_d;
            gap_q   <= gap_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_pulse = pulse_q;
    assign grant       = grant_q;
    assign overflow    = ovf_q;
    assign busy        = any_pending || (state_q != StIdle);

endmodule

// File: doc/score_pulse_scheduler.md
# score_pulse_scheduler

Collects score-award requests from several game sources (enemy kills, boss hits, bonuses) and serialises them into a single stream of one-cycle `count_pulse` strobes. The stream drives the least-significant digit counter of the score chain. Each source has its own saturating pending accumulator. A round-robin arbiter picks which source drains next, and an optional gap between pulses gives a visible tally effect.

## Interface
Parameters:
- `NUM_REQ`, 4: number of score sources.
- `POINTS_WIDTH`, 6: width of one source's points value per award.
- `PENDING_WIDTH`, 8: width of each per-source pending accumulator and of the drain counter.
- `PULSE_GAP`, 0: idle cycles inserted between consecutive `count_pulse` strobes (0 = back-to-back).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `add_pulse`  in  NUM_REQ  one-cycle award strobe per source.
- `add_points`  in  NUM_REQ*POINTS_WIDTH  points per source; source i occupies bits [i*POINTS_WIDTH +: POINTS_WIDTH].
- `freeze`  in  1  pause/game-over hold; blocks new grants and stalls pulsing.
- `count_pulse`  out  1  one-cycle increment strobe to the digit chain.
- `grant`  out  NUM_REQ  one-hot; identifies the source currently draining.
- `busy`  out  1  high while any pending is nonzero or the FSM is not IDLE.
- `overflow`  out  1  sticky; set when any accumulator saturates.

## Operation
- **Pending accumulators**
  - When `add_pulse[i]` is high: pending[i] <= pending[i] + add_points[i], saturating at 2^PENDING_WIDTH-1.
  - Saturation sets `overflow`, which stays set until reset.
  - Awards are accepted regardless of `freeze` or FSM state.
  - Zero-points awards change nothing.
- **FSM states: IDLE, LOAD, PULSE, GAP**
  - IDLE
    - If `freeze` is low and any pending is nonzero, select a winner by round-robin, starting the search at last_grant+1 and wrapping mod NUM_REQ.
    - Register the winner into `grant` and last_grant, then go to LOAD.
  - LOAD
    - drain <= pending[g].
    - pending[g] <= 0, or <= add_points[g] if `add_pulse[g]` is high in the same cycle. An award arriving during LOAD is never lost.
    - Go to PULSE.
  - PULSE
    - If `freeze` is high: stay, `count_pulse` = 0.
    - Otherwise `count_pulse` = 1 for this cycle and drain <= drain-1.
    - If drain was 1: go to IDLE and clear `grant`.
    - Else if PULSE_GAP > 0: go to GAP with gap counter = PULSE_GAP.
    - Else stay in PULSE.
  - GAP
    - Decrement the gap counter; the counter does not decrement while `freeze` is high.
    - Return to PULSE when it reaches 0.
- **Outputs**
  - `grant` is valid from the LOAD cycle through the last PULSE cycle, and zero otherwise.
  - The total number of pulses equals the total awarded points, minus any amount lost to saturation.
- **Reset**
  - Effective in any state, including mid-drain; the undelivered drain is discarded.
  - All pending, drain and gap counters go to 0; state to IDLE.
  - `count_pulse`, `grant`, `busy` and `overflow` go to 0.
  - last_grant goes to NUM_REQ-1, so source 0 has first priority after reset.

## Timing
- `count_pulse` and `grant` are registered outputs.
- Single award of N points on source i at cycle 0, idle FSM, `freeze` low:
  - pending updates at cycle 1.
  - LOAD at cycle 2.
  - Pulses at cycles 3 + k*(PULSE_GAP+1), for k = 0..N-1.
  - IDLE in the cycle after the last pulse.
- Back-to-back grants: the next LOAD is 2 cycles after the previous last pulse (1 IDLE cycle, then LOAD).
- Maximum rate is one pulse per cycle (PULSE_GAP = 0). This is legal for the digit chain: each carry is registered, so the next digit receives it one cycle later.
- `busy` is combinational from the state and the pending values.
- `freeze` sampled high inserts exactly one stalled cycle per cycle it is held; no pulse is dropped or duplicated.

## Test plan
- Reset, then `add_pulse[0]` with points=3 at cycle 0, PULSE_GAP=0 -> `count_pulse` high at cycles 3,4,5; `grant`=0001 over cycles 2–5; `busy` low from cycle 6.
- Sources 0,1,2 each award 2 points in the same cycle -> grants in order 0,1,2; 6 pulses total; each grant separated from the next by one IDLE cycle.
- PULSE_GAP=2, source 3 awards 4 points -> pulses spaced 3 cycles apart: cycles 3,6,9,12.
- `freeze` raised for 5 cycles after the 2nd of 5 pulses -> no pulses while frozen; the remaining 3 pulses follow; the total is exactly 5.
- Source 1 awards 63 points on five consecutive cycles with PENDING_WIDTH=8 -> pending saturates at 255, `overflow` set; exactly 255 pulses are delivered and `overflow` stays high afterward.
- Assert `reset` mid-drain with 10 pulses remaining -> next cycle: `count_pulse`=0, `grant`=0, `busy`=0, `overflow`=0; no further pulses without new awards.
